// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter with a one-word holding register and back-to-back framing
module uart_tx_frame #(
    parameter int CLK_PER_BIT = 87,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] CNT_LAST  = 16'(CLK_PER_BIT - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic [15:0]            clk_cnt_q, clk_cnt_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;

    logic accept;
    logic bit_end;
    logic stop_last;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return (PARITY == 1) ? ~^w : ^w;
    endfunction

    assign accept    = valid && !hold_full_q;
    assign bit_end   = (clk_cnt_q == CNT_LAST);
    assign stop_last = bit_end && (stop_cnt_q == STOP_LAST);

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;

        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_end ? 16'd0 : clk_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    shift_d   = data_in;
                    par_d     = parity_of(data_in);
                    clk_cnt_d = 16'd0;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 4'd0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == BIT_LAST) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            S_STOP: begin
                // The held word wins over a fresh offer; ready is low then anyway.
                if (stop_last) begin
                    if (hold_full_q) begin
                        state_d     = S_START;
                        shift_d     = hold_q;
                        par_d       = parity_of(hold_q);
                        hold_full_d = 1'b0;
                        tx_d        = 1'b0;
                    end else if (accept) begin
                        state_d = S_START;
                        shift_d = data_in;
                        par_d   = parity_of(data_in);
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else if (bit_end) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (accept && (state_q != S_IDLE) && !((state_q == S_STOP) && stop_last)) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE) || hold_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= 16'd0;
            bit_idx_q   <= 4'd0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_cnt_q  <= stop_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign ready = ~hold_full_q;
    assign tx    = tx_q;
    assign busy  = busy_q;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter. Serialises words of 5–9 data bits, LSB first, with optional odd or even parity and one or two stop bits. It accepts data over a valid/ready handshake and holds one further word in a holding register, so back-to-back frames go out with no idle gap. It sits between the TX-side async FIFO read port and the serial pin, in the same clock domain as the FIFO read side.

## Interface
- CLK_PER_BIT, 87, clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even. Value 3 is illegal.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

- clk, input, 1, single clock; every register changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- data_in, input, DATA_BITS, word to send; sampled only on an accept cycle.
- valid, input, 1, data_in is valid.
- ready, output, 1, the block can take a word this cycle. Equals NOT hold_full (registered state, no combinational path from valid).
- tx, output, 1, serial line, registered. Idle level is 1.
- busy, output, 1, registered. High while a frame is being sent or a word is pending.

## Operation
- An accept occurs on a rising edge where valid && ready.
- Frame layout: start bit (0), then data_in[0]..data_in[DATA_BITS-1], then the parity bit if PARITY != 0, then STOP_BITS stop bits (1).
- Frame length: F = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits.
- Parity bit:
  - Odd mode: the parity bit is ~^data, so the data bits plus parity contain an odd number of ones.
  - Even mode: the parity bit is ^data.
  - Parity is computed from the shifter contents at frame load.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START on an accept. data_in loads directly into the shifter; the holding register is bypassed.
  - START to DATA after CLK_PER_BIT cycles.
  - DATA advances bit_idx every CLK_PER_BIT cycles. After bit DATA_BITS-1 it goes to PARITY, or to STOP when PARITY is 0.
  - PARITY to STOP after CLK_PER_BIT cycles.
  - STOP lasts STOP_BITS*CLK_PER_BIT cycles. On its last cycle:
    - holding register full: load it into the shifter, clear hold_full, go to START;
    - else an accept this cycle: load data_in into the shifter, go to START;
    - else go to IDLE.
- Accept outside IDLE: any accept in START/DATA/PARITY/STOP other than on the last STOP cycle writes data_in to the holding register and sets hold_full.
- Counter widths: clk_cnt is 16 bits and wraps to 0 at CLK_PER_BIT-1. bit_idx is 4 bits. The stop counter is 1 bit.
- busy = (state != IDLE) || hold_full.

## Timing
- Reset (asynchronous, immediate): tx=1, busy=0, ready=1, state=IDLE, hold_full=0, all counters 0.
- Reset asserted mid-frame aborts the frame and discards any pending word. tx returns to 1 without waiting for a clock.
- Latency: accept at edge k in IDLE means tx=0 and busy=1 from edge k onward. Each bit holds for exactly CLK_PER_BIT cycles.
- The last stop bit ends F*CLK_PER_BIT cycles after edge k.
  - With no pending word, busy falls at that edge and tx stays 1.
  - With a pending word, tx drops to 0 at that same edge, giving zero idle cycles between frames.
- ready falls on the edge after a holding-register write. It rises on the edge that moves the held word into the shifter.
- data_in and valid are ignored while ready=0. The held word is never overwritten.
- valid may stay high across several cycles. Exactly one word is taken per accepting edge.

## Test plan
- Defaults with CLK_PER_BIT=4: send 0xA5. Required: tx = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles. busy high for exactly 40 cycles, then 0.
- DATA_BITS=7, PARITY=1, STOP_BITS=2: send 0x03. Required: parity bit = 1, frame = 11 bits = 44 cycles. A reference RX model reads 0x03 with no parity error.
- PARITY=2: send 0xFF then 0x01. Required: parity bits 0 and 1 respectively.
- Hold valid high with 0x11, 0x22, 0x33 offered in sequence.
  - Required: 0x11 accepted at t0, 0x22 accepted the next cycle, then ready low.
  - Frames go out back-to-back with no 1-level gap. 0x33 is accepted at the boundary of frame 1.
- Assert rst_n=0 mid-DATA of 0x5A with a pending word. Required: tx=1, busy=0, ready=1 immediately. After release nothing is transmitted.
- valid pulse on the exact last STOP cycle with the holding register empty. Required: the word is accepted, and the start bit follows immediately with no idle cycle.
